// File: rtl/wb_pkg.sv
// Shared types and sizes for the writeback arbiter.
// Included by wb_if, wb_fifo and wb_arbiter.
package wb_pkg;
  localparam int XLEN       = 64;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;
endpackage

// File: rtl/wb_if.sv
// Writeback arbiter bus: result inputs, scoreboard and RF write port.
// WB_FWD_EN adds the same-cycle forwarding read ports.
interface wb_if;
  import wb_pkg::*;

  logic                  alu_valid;
  logic [REG_ADDR_W-1:0] alu_rd;
  logic [XLEN-1:0]       alu_data;
  logic                  lsu_valid;
  logic                  lsu_ready;
  logic [REG_ADDR_W-1:0] lsu_rd;
  logic [XLEN-1:0]       lsu_data;
  logic                  iss_valid;
  logic [REG_ADDR_W-1:0] iss_rd;
  logic [NUM_REGS-1:0]   busy_mask;
  logic                  stall_req;
  logic [REG_ADDR_W-1:0] rf_waddr;
  logic [XLEN-1:0]       rf_wdata;
  logic                  rf_wr_n;
`ifdef WB_FWD_EN
  logic [REG_ADDR_W-1:0] fwd_raddr1;
  logic [REG_ADDR_W-1:0] fwd_raddr2;
  logic                  fwd_hit1;
  logic                  fwd_hit2;
  logic [XLEN-1:0]       fwd_data1;
  logic [XLEN-1:0]       fwd_data2;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data,
    output iss_valid, iss_rd,
    output fwd_raddr1, fwd_raddr2,
    input  lsu_ready, busy_mask, stall_req,
    input  rf_waddr, rf_wdata, rf_wr_n,
    input  fwd_hit1, fwd_hit2,
    input  fwd_data1, fwd_data2
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    input  iss_valid, iss_rd,
    input  fwd_raddr1, fwd_raddr2,
    output lsu_ready, busy_mask, stall_req,
    output rf_waddr, rf_wdata, rf_wr_n,
    output fwd_hit1, fwd_hit2,
    output fwd_data1, fwd_data2
  );
`else
  modport master (
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data,
    output iss_valid, iss_rd,
    input  lsu_ready, busy_mask, stall_req,
    input  rf_waddr, rf_wdata, rf_wr_n
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    input  iss_valid, iss_rd,
    output lsu_ready, busy_mask, stall_req,
    output rf_waddr, rf_wdata, rf_wr_n
  );
`endif
endinterface

// File: rtl/wb_fifo.sv
// Circular queue of long-latency writeback requests.
// DEPTH must be a power of two so pointers wrap naturally.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    i_push,
  input  wb_req_t i_data,
  input  logic    i_pop,
  output wb_req_t o_head,
  output logic    o_full,
  output logic    o_empty
);
  localparam int AW = $clog2(DEPTH);

  wb_req_t       r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_cnt;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_head  = r_mem[r_rptr];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end
endmodule

// File: rtl/wb_arbiter.sv
// Register-file write port arbiter with busy scoreboard and starvation stall.
// Define WB_FWD_EN for combinational forwarding of the registered write.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int LQ_DEPTH     = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic clk,
  input logic reset,
  wb_if.slave bus
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  wb_req_t               w_push_req;
  wb_req_t               w_head;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_alu_win;
  logic                  w_starve_hit;
  logic [CW-1:0]         w_starve_inc;
  logic [NUM_REGS-1:0]   w_busy_nxt;

  logic                  r_wr_n;
  logic [REG_ADDR_W-1:0] r_waddr;
  logic [XLEN-1:0]       r_wdata;
  logic [NUM_REGS-1:0]   r_busy;
  logic                  r_stall;
  logic [CW-1:0]         r_starve;

  assign w_push_req = '{rd: bus.lsu_rd, data: bus.lsu_data};
  assign bus.lsu_ready = ~w_full & ~reset;
  assign w_push = bus.lsu_valid & bus.lsu_ready;
  // x0 from the ALU is a no-op, so the queue may use the slot
  assign w_alu_win = bus.alu_valid & (bus.alu_rd != '0);
  assign w_pop = ~w_alu_win & ~w_empty;
  assign w_starve_hit = w_full & w_alu_win;
  assign w_starve_inc = r_starve + 1'b1;

  wb_fifo #(
    .DEPTH (LQ_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (w_push_req),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // an issue to the same register outranks the retiring pop
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_pop && w_head.rd != '0)
      w_busy_nxt[w_head.rd] = 1'b0;
    if (bus.iss_valid && bus.iss_rd != '0)
      w_busy_nxt[bus.iss_rd] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_n  <= 1'b1;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_wr_n <= 1'b1;
      unique case (1'b1)
        w_alu_win: begin
          r_wr_n  <= 1'b0;
          r_waddr <= bus.alu_rd;
          r_wdata <= bus.alu_data;
        end
        w_pop: begin
          if (w_head.rd != '0) begin
            r_wr_n  <= 1'b0;
            r_waddr <= w_head.rd;
            r_wdata <= w_head.data;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy   <= '0;
      r_stall  <= 1'b0;
      r_starve <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      if (w_starve_hit &&
          w_starve_inc == CW'(STARVE_LIMIT)) begin
        r_stall  <= 1'b1;
        r_starve <= '0;
      end else if (w_starve_hit) begin
        r_stall  <= 1'b0;
        r_starve <= w_starve_inc;
      end else begin
        r_stall  <= 1'b0;
        r_starve <= '0;
      end
    end
  end

  assign bus.rf_wr_n   = r_wr_n;
  assign bus.rf_waddr  = r_waddr;
  assign bus.rf_wdata  = r_wdata;
  assign bus.busy_mask = r_busy;
  assign bus.stall_req = r_stall;

`ifdef WB_FWD_EN
  assign bus.fwd_hit1 = ~r_wr_n &
    (r_waddr == bus.fwd_raddr1) & (bus.fwd_raddr1 != '0);
  assign bus.fwd_hit2 = ~r_wr_n &
    (r_waddr == bus.fwd_raddr2) & (bus.fwd_raddr2 != '0);
  assign bus.fwd_data1 = r_wdata;
  assign bus.fwd_data2 = r_wdata;
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed table plus
// randomized traffic against a queue-based reference model.
module tb_wb_arbiter;
  import wb_pkg::*;

  localparam int LQ_DEPTH     = 2;
  localparam int STARVE_LIMIT = 4;

  logic clk;
  logic reset;

  wb_if bus ();

  wb_arbiter #(
    .LQ_DEPTH     (LQ_DEPTH),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit        rst;
    bit        av;
    bit [4:0]  ard;
    bit [63:0] ad;
    bit        lv;
    bit [4:0]  lrd;
    bit [63:0] ld;
    bit        iv;
    bit [4:0]  ird;
    bit        e_rdy;
    bit        e_wrn;
    bit [4:0]  e_addr;
    bit [63:0] e_data;
    bit [31:0] e_busy;
    bit        e_stall;
  } vec_t;

  vec_t tbl[$];
  vec_t idle_v;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  wb_req_t   m_q[$];
  bit [31:0] m_busy  = '0;
  int        m_cnt   = 0;
  bit        m_stall = 1'b0;
  bit        m_wr_n  = 1'b1;
  bit [4:0]  m_addr  = '0;
  bit [63:0] m_data  = '0;

  function automatic vec_t mk(
    bit rst, bit av, bit [4:0] ard, bit [63:0] ad,
    bit lv, bit [4:0] lrd, bit [63:0] ld,
    bit iv, bit [4:0] ird,
    bit e_rdy, bit e_wrn, bit [4:0] e_addr,
    bit [63:0] e_data, bit [31:0] e_busy, bit e_stall);
    vec_t v;
    v.rst = rst; v.av = av; v.ard = ard; v.ad = ad;
    v.lv = lv; v.lrd = lrd; v.ld = ld;
    v.iv = iv; v.ird = ird;
    v.e_rdy = e_rdy; v.e_wrn = e_wrn;
    v.e_addr = e_addr; v.e_data = e_data;
    v.e_busy = e_busy; v.e_stall = e_stall;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h @%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    reset         = v.rst;
    bus.alu_valid = v.av;
    bus.alu_rd    = v.ard;
    bus.alu_data  = v.ad;
    bus.lsu_valid = v.lv;
    bus.lsu_rd    = v.lrd;
    bus.lsu_data  = v.ld;
    bus.iss_valid = v.iv;
    bus.iss_rd    = v.ird;
`ifdef WB_FWD_EN
    bus.fwd_raddr1 = 5'($urandom_range(0, 31));
    bus.fwd_raddr2 = m_addr;
`endif
  endtask

  // one clock edge of the spec's rules, applied to the inputs now on the bus
  task automatic model_step();
    bit      full;
    bit      rdy;
    bit      alu;
    bit      pop;
    wb_req_t h;
    wb_req_t p;
    if (reset) begin
      m_q.delete();
      m_busy  = '0;
      m_cnt   = 0;
      m_stall = 1'b0;
      m_wr_n  = 1'b1;
      m_addr  = '0;
      m_data  = '0;
      return;
    end
    full = (m_q.size() == LQ_DEPTH);
    rdy  = !full;
    alu  = bus.alu_valid && bus.alu_rd != 0;
    pop  = !alu && m_q.size() > 0;
    m_wr_n = 1'b1;
    if (alu) begin
      m_wr_n = 1'b0;
      m_addr = bus.alu_rd;
      m_data = bus.alu_data;
    end else if (pop) begin
      h = m_q.pop_front();
      if (h.rd != 0) begin
        m_wr_n = 1'b0;
        m_addr = h.rd;
        m_data = h.data;
        m_busy[h.rd] = 1'b0;
      end
    end
    if (bus.iss_valid && bus.iss_rd != 0)
      m_busy[bus.iss_rd] = 1'b1;
    m_busy[0] = 1'b0;
    if (full && alu) begin
      m_cnt++;
      m_stall = (m_cnt == STARVE_LIMIT);
      if (m_stall) m_cnt = 0;
    end else begin
      m_cnt   = 0;
      m_stall = 1'b0;
    end
    if (bus.lsu_valid && rdy) begin
      p.rd   = bus.lsu_rd;
      p.data = bus.lsu_data;
      m_q.push_back(p);
    end
  endtask

  task automatic tick(input bit has_exp, input vec_t v);
    bit m_rdy;
    @(negedge clk);
    m_rdy = !reset && (m_q.size() < LQ_DEPTH);
    chk("lsu_ready", bus.lsu_ready, m_rdy);
    if (has_exp) chk("tbl_lsu_ready", bus.lsu_ready, v.e_rdy);
    @(posedge clk);
    model_step();
    #1;
    chk("rf_wr_n", bus.rf_wr_n, m_wr_n);
    chk("rf_waddr", bus.rf_waddr, m_addr);
    chk("rf_wdata", bus.rf_wdata, m_data);
    chk("busy_mask", bus.busy_mask, m_busy);
    chk("stall_req", bus.stall_req, m_stall);
`ifdef WB_FWD_EN
    chk("fwd_hit1", bus.fwd_hit1,
        !m_wr_n && m_addr == bus.fwd_raddr1 &&
        bus.fwd_raddr1 != 0);
    chk("fwd_hit2", bus.fwd_hit2,
        !m_wr_n && m_addr != 0);
    if (!m_wr_n) chk("fwd_data2", bus.fwd_data2, m_data);
`endif
    if (has_exp) begin
      chk("tbl_rf_wr_n", bus.rf_wr_n, v.e_wrn);
      chk("tbl_rf_waddr", bus.rf_waddr, v.e_addr);
      chk("tbl_rf_wdata", bus.rf_wdata, v.e_data);
      chk("tbl_busy", bus.busy_mask, v.e_busy);
      chk("tbl_stall", bus.stall_req, v.e_stall);
    end
  endtask

  initial begin
    vec_t v;
    idle_v = mk(0,0,0,0, 0,0,0, 0,0, 0,0,0,0,0,0);
    v = idle_v;
    v.rst = 1'b1;
    drive(v);
    tick(0, v);
    tick(0, v);

    //       rst av rd dat     lv rd dat     iv rd  rdy wrn ad dat     busy      st
    // ALU only, then idle
    tbl.push_back(mk(0,1,5,64'hDEAD,0,0,0,0,0, 1,0,5,64'hDEAD,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 1,1,5,64'hDEAD,0,0));
    // issue x9, LSU answers 3 cycles later
    tbl.push_back(mk(0,0,0,0,0,0,0,1,9, 1,1,5,64'hDEAD,32'h200,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 1,1,5,64'hDEAD,32'h200,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 1,1,5,64'hDEAD,32'h200,0));
    tbl.push_back(mk(0,0,0,0,1,9,64'h42,0,0, 1,1,5,64'hDEAD,32'h200,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 1,0,9,64'h42,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 1,1,9,64'h42,0,0));
    // ALU to x0 lets the queued {7,0x11} drain
    tbl.push_back(mk(0,0,0,0,1,7,64'h11,0,0, 1,1,9,64'h42,0,0));
    tbl.push_back(mk(0,1,0,64'h99,0,0,0,0,0, 1,0,7,64'h11,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 1,1,7,64'h11,0,0));
    // set and clear of x12 on the same edge
    tbl.push_back(mk(0,0,0,0,1,12,64'hC,1,12, 1,1,7,64'h11,32'h1000,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,12, 1,0,12,64'hC,32'h1000,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 1,1,12,64'hC,32'h1000,0));
    // fill queue under ALU pressure until stall_req
    tbl.push_back(mk(0,1,3,64'h30,1,4,64'h44,0,0, 1,0,3,64'h30,32'h1000,0));
    tbl.push_back(mk(0,1,3,64'h31,1,5,64'h55,0,0, 1,0,3,64'h31,32'h1000,0));
    tbl.push_back(mk(0,1,3,64'h32,1,6,64'h66,0,0, 0,0,3,64'h32,32'h1000,0));
    tbl.push_back(mk(0,1,3,64'h33,0,0,0,0,0, 0,0,3,64'h33,32'h1000,0));
    tbl.push_back(mk(0,1,3,64'h34,0,0,0,0,0, 0,0,3,64'h34,32'h1000,0));
    tbl.push_back(mk(0,1,3,64'h35,0,0,0,0,0, 0,0,3,64'h35,32'h1000,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,4,64'h44,32'h1000,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 1,0,5,64'h55,32'h1000,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 1,1,5,64'h55,32'h1000,0));
    // two queued entries with pending bits, then reset
    tbl.push_back(mk(0,1,1,64'h1,1,20,64'hA,1,20, 1,0,1,64'h1,32'h101000,0));
    tbl.push_back(mk(0,1,1,64'h2,1,21,64'hB,1,21, 1,0,1,64'h2,32'h301000,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,0,0, 0,1,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 1,1,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 1,1,0,0,0,0));

    foreach (tbl[i]) begin
      drive(tbl[i]);
      tick(1, tbl[i]);
    end

    v = idle_v;
    v.rst = 1'b1;
    drive(v);
    tick(0, v);

    for (int i = 0; i < 3000; i++) begin
      v = idle_v;
      v.rst = ($urandom_range(0, 199) == 0);
      v.av  = m_stall ? 1'b0 : ($urandom_range(0, 9) < 7);
      v.ard = 5'($urandom_range(0, 31));
      v.ad  = {$urandom, $urandom};
      v.lv  = ($urandom_range(0, 1) == 1);
      v.lrd = 5'($urandom_range(0, 31));
      v.ld  = {$urandom, $urandom};
      v.iv  = ($urandom_range(0, 3) == 0);
      v.ird = 5'($urandom_range(0, 31));
      drive(v);
      tick(0, v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
